regfile_scoreboard: RTL

- Integer register file plus per-register pending-write scoreboard.
- Its write port is the far end of the writeback stage's wr_addr/wr_data/wr_enable interface, and it consumes the writeback flush.
- Decode uses its two read ports for operands and its busy flags for RAW-hazard stalls.
- It records each issued destination register and retires that record when writeback writes the register.

---
 rtl/regfile_scoreboard.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Integer register file with a per-register pending-write scoreboard.
//   Decode reads operands through two combinational read ports and uses the
//   busy flags to stall on RAW hazards. Every issued destination register
//   bumps that register's pending counter. Each writeback to the register
//   retires one pending writer. A flush from writeback clears all pending
//   records, because flushed instructions never reach writeback.
//
// Ports
//   clk                 clock
//   reset               synchronous reset, active low (0 = reset)
//   rs1_addr/rs1_data   read port 1 (combinational data)
//   rs2_addr/rs2_data   read port 2 (combinational data)
//   rs1_busy/rs2_busy   operand register has an outstanding writer
//   wr_addr/wr_data     writeback destination and data
//   wr_enable           writeback write strobe
//   issue_valid         decode issues an instruction this cycle
//   issue_we            issued instruction writes a register
//   issue_rd            issued destination register
//   issue_full          pending counter of issue_rd is saturated (stall)
//   flush               pipeline flush from writeback

`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 4
`endif
`ifndef REG_DATA_SIZE
`define REG_DATA_SIZE 31
`endif

module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [`REG_ADDR_SIZE:0]   rs1_addr,
  output logic [`REG_DATA_SIZE:0]   rs1_data,
  input  logic [`REG_ADDR_SIZE:0]   rs2_addr,
  output logic [`REG_DATA_SIZE:0]   rs2_data,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  input  logic [`REG_ADDR_SIZE:0]   wr_addr,
  input  logic [`REG_DATA_SIZE:0]   wr_data,
  input  logic                      wr_enable,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic [`REG_ADDR_SIZE:0]   issue_rd,
  output logic                      issue_full,
  input  logic                      flush
);

  localparam int AW = `REG_ADDR_SIZE + 1;
  localparam int DW = `REG_DATA_SIZE + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Addresses at or beyond NUM_REGS behave like x0: read 0, never busy.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // ---------------------------------------------------------------------
  // Register storage. Entry 0 is never written; reads of x0 are forced to 0.
  // ---------------------------------------------------------------------
  logic [DW-1:0] regs_reg [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_enable && (wr_addr != '0) && addr_ok(wr_addr)) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Pending-writer counters, one per architectural register.
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
    if (gi == 0) begin : g_zero
      assign cnt[gi] = '0;
    end else begin : g_live
      logic [CNT_W-1:0] cnt_reg;
      logic             inc;
      logic             dec;

      // issue_full already excludes saturated counters, so inc never wraps.
      assign inc = issue_valid & issue_we & (issue_rd == AW'(gi))
                   & ~issue_full & ~flush;
      // A writeback with nothing pending is ignored, so no underflow.
      assign dec = wr_enable & (wr_addr == AW'(gi)) & (cnt_reg != '0);

      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (flush) begin
          cnt_reg <= '0;
        end else if (inc && !dec) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (dec && !inc) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
        // inc && dec: the older writer retires and the newer one takes its
        // place, so the count is unchanged.
      end

      assign cnt[gi] = cnt_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports with optional same-cycle forwarding of the writeback.
  // ---------------------------------------------------------------------
  logic [AW-1:0] rd_addr [2];
  logic [DW-1:0] rd_data [2];
  logic          rd_busy [2];

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic             hit;
    logic [DW-1:0]    stored;
    logic [CNT_W-1:0] rd_cnt;
    logic [DW-1:0]    data_sel;
    logic             busy_sel;

    always_comb begin
      hit      = (BYPASS != 0) && wr_enable && (wr_addr == rd_addr[gi]);
      stored   = '0;
      rd_cnt   = '0;
      data_sel = '0;
      busy_sel = 1'b0;
      if (addr_ok(rd_addr[gi])) begin
        stored = regs_reg[rd_addr[gi]];
        rd_cnt = cnt[rd_addr[gi]];
      end
      if (rd_addr[gi] != '0) begin
        data_sel = hit ? wr_data : stored;
        // When the last pending writer is retiring right now, its value is
        // forwarded, so the operand is not a hazard. With more writers
        // still in flight the forwarded value is stale and decode must wait.
        if (hit && (rd_cnt == CNT_W'(1))) begin
          busy_sel = 1'b0;
        end else begin
          busy_sel = (rd_cnt != '0);
        end
      end
    end

    assign rd_data[gi] = data_sel;
    assign rd_busy[gi] = busy_sel;
  end

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];
  assign rs1_busy = rd_busy[0];
  assign rs2_busy = rd_busy[1];

  // ---------------------------------------------------------------------
  // Saturation stall. A writeback to the same register in this cycle frees
  // a slot, so the issue can proceed.
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] issue_cnt;

  assign issue_cnt  = addr_ok(issue_rd) ? cnt[issue_rd] : '0;
  assign issue_full = issue_valid & issue_we & (issue_rd != '0)
                      & (issue_cnt == CNT_MAX)
                      & ~(wr_enable & (wr_addr == issue_rd));

endmodule
